// File: rtl/uart_frame_alu_if.sv
// ============================================================================
// uart_frame_alu_if : byte-stream handshake bundle for uart_frame_alu
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_frame_alu_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       op_done;
    logic       frame_err;
    logic       rx_drop;

    modport master (
        output rx_valid, rx_byte, tx_ready,
        input  tx_byte, tx_valid, busy, op_done, frame_err, rx_drop
    );

    modport slave (
        input  rx_valid, rx_byte, tx_ready,
        output tx_byte, tx_valid, busy, op_done, frame_err, rx_drop
    );
endinterface

`default_nettype wire

// File: rtl/uart_frame_alu.sv
// ============================================================================
// uart_frame_alu : collects opcode/A/B byte frame, executes one integer op,
//                  streams back a status byte and the result LSB first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_frame_alu #(
    parameter int OPER_W      = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             rst,
    uart_frame_alu_if.slave  bus
);
    localparam int NB = OPER_W / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [OPER_W+3:0] c_nine = (OPER_W+4)'(9);
    localparam logic signed [OPER_W+3:0] c_five = (OPER_W+4)'(5);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RX_A = 3'd1,
        S_RX_B = 3'd2,
        S_EXEC = 3'd3,
        S_TX   = 3'd4
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_inc;
    logic [TW-1:0]       r_tmo;
    logic [7:0]          r_op;
    logic [OPER_W-1:0]   r_a, r_b, r_res;
    logic                r_flag, r_bad;
    logic [7:0]          r_tx_byte;
    logic                r_tx_valid, r_op_done, r_frame_err, r_rx_drop;
    logic                w_timeout, w_last_rx, w_last_tx;
    logic [OPER_W-1:0]   w_res;
    logic                w_flag, w_bad;
    logic [OPER_W:0]     w_sum;
    logic signed [OPER_W+3:0] w_ext, w_mul, w_quo;
    logic [7:0]          w_resp [0:NB];

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = ((r_state == S_RX_A) || (r_state == S_RX_B)) &&
                       (r_tmo == TW'(TIMEOUT_CYC));
    assign w_last_rx = bus.rx_valid && (r_cnt == CW'(NB - 1));
    assign w_last_tx = r_tx_valid && bus.tx_ready && (r_cnt == CW'(NB));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.rx_valid) w_next = S_RX_A;
            S_RX_A: begin
                if (w_timeout)      w_next = S_IDLE;
                else if (w_last_rx) w_next = S_RX_B;
            end
            S_RX_B: begin
                if (w_timeout)      w_next = S_IDLE;
                else if (w_last_rx) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_TX;
            S_TX:   if (w_last_tx) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Celsius-to-Fahrenheit runs 4 bits wider so A*9 cannot overflow; '/' truncates toward zero
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_ext  = {{4{r_a[OPER_W-1]}}, r_a};
        w_mul  = w_ext * c_nine;
        w_quo  = w_mul / c_five;
        w_res  = '0;
        w_flag = 1'b0;
        w_bad  = 1'b0;
        case (r_op)
            8'h00: w_res = r_a;
            8'h01: begin
                w_res  = w_sum[OPER_W-1:0];
                w_flag = w_sum[OPER_W];
            end
            8'h02: begin
                w_res  = r_a - r_b;
                w_flag = (r_a < r_b);
            end
            8'h03: w_res = r_a & r_b;
            8'h04: w_res = r_a | r_b;
            8'h05: w_res = r_a ^ r_b;
            8'h06: w_res = OPER_W'(w_quo) + OPER_W'(32);
            default: w_bad = 1'b1;
        endcase
    end

    assign w_resp[0] = {r_bad, 6'b000000, r_flag};
    for (genvar gi = 0; gi < NB; gi++) begin : g_resp
        assign w_resp[gi+1] = r_res[gi*8 +: 8];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_flag      <= 1'b0;
            r_bad       <= 1'b0;
            r_tx_byte   <= '0;
            r_tx_valid  <= 1'b0;
            r_op_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_drop   <= 1'b0;
        end else begin
            r_op_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_drop   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_tmo <= '0;
                    if (bus.rx_valid) r_op <= bus.rx_byte;
                end
                S_RX_A, S_RX_B: begin
                    if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_cnt       <= '0;
                        r_tmo       <= '0;
                    end else if (bus.rx_valid) begin
                        r_tmo <= '0;
                        if (r_state == S_RX_A) r_a[{r_cnt, 3'b000} +: 8] <= bus.rx_byte;
                        else                   r_b[{r_cnt, 3'b000} +: 8] <= bus.rx_byte;
                        r_cnt <= w_last_rx ? '0 : w_cnt_inc;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_res     <= w_res;
                    r_flag    <= w_flag;
                    r_bad     <= w_bad;
                    r_cnt     <= '0;
                    r_rx_drop <= bus.rx_valid;
                end
                S_TX: begin
                    r_rx_drop <= bus.rx_valid;
                    if (!r_tx_valid) begin
                        r_tx_byte  <= w_resp[r_cnt];
                        r_tx_valid <= 1'b1;
                    end else if (bus.tx_ready) begin
                        if (r_cnt == CW'(NB)) begin
                            r_tx_valid <= 1'b0;
                            r_op_done  <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt     <= w_cnt_inc;
                            r_tx_byte <= w_resp[w_cnt_inc];
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.tx_byte   = r_tx_byte;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.op_done   = r_op_done;
    assign bus.frame_err = r_frame_err;
    assign bus.rx_drop   = r_rx_drop;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_alu.sv
// ============================================================================
// tb_uart_frame_alu : directed scoreboard bench for 32-bit and 16-bit engines
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_alu_if b32 ();
    uart_frame_alu_if b16 ();

    uart_frame_alu #(.OPER_W(32), .TIMEOUT_CYC(50)) dut32 (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (b32)
    );

    uart_frame_alu #(.OPER_W(16), .TIMEOUT_CYC(50)) dut16 (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (b16)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs32 [0:511];
    logic [7:0] obs16 [0:511];
    int wr32 = 0, wr16 = 0, rd32 = 0, rd16 = 0;
    int done32 = 0, done16 = 0, ferr32 = 0, drop32 = 0, busy_at_done = 0;
    int base_done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (b32.tx_valid && b32.tx_ready && wr32 < 512) begin
                obs32[wr32] = b32.tx_byte;
                wr32++;
            end
            if (b16.tx_valid && b16.tx_ready && wr16 < 512) begin
                obs16[wr16] = b16.tx_byte;
                wr16++;
            end
            if (b32.op_done) begin
                done32++;
                if (b32.busy) busy_at_done++;
            end
            if (b16.op_done) begin
                done16++;
                if (b16.busy) busy_at_done++;
            end
            if (b32.frame_err) ferr32++;
            if (b32.rx_drop)   drop32++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] model(input int w, input logic [7:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, r;
        logic [64:0] s;
        logic        flag, bad;
        longint      sa, t;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = '0; flag = 1'b0; bad = 1'b0;
        case (op)
            8'h00: r = a;
            8'h01: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0] & mask; flag = s[w]; end
            8'h02: begin r = (a - b) & mask; flag = (a < b); end
            8'h03: r = a & b;
            8'h04: r = a | b;
            8'h05: r = a ^ b;
            8'h06: begin
                sa = $signed(a << (64 - w)) >>> (64 - w);
                t  = sa * 9 / 5;
                r  = 64'(t + 32) & mask;
            end
            default: bad = 1'b1;
        endcase
        return {bad, 6'b000000, flag, r};
    endfunction

    task automatic send_byte(input bit sel, input logic [7:0] d);
        if (sel) begin b16.rx_valid = 1'b1; b16.rx_byte = d; end
        else     begin b32.rx_valid = 1'b1; b32.rx_byte = d; end
        @(posedge clk); #1;
        b16.rx_valid = 1'b0;
        b32.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] op, input logic [63:0] a,
                              input logic [63:0] b, input bit expect_resp);
        int w;
        logic [71:0] m;
        w = sel ? 16 : 32;
        if (expect_resp) begin
            m = model(w, op, a, b);
            exp_q.push_back(m[71:64]);
            for (int i = 0; i < w / 8; i++) exp_q.push_back(m[8*i +: 8]);
        end
        base_done = sel ? done16 : done32;
        send_byte(sel, op);
        for (int i = 0; i < w / 8; i++) send_byte(sel, a[8*i +: 8]);
        for (int i = 0; i < w / 8; i++) send_byte(sel, b[8*i +: 8]);
    endtask

    task automatic wait_resp(input bit sel, input string tag);
        int nexp, rd0, wr_now;
        logic [7:0] e;
        logic [8:0] o;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ((sel ? done16 : done32) > base_done) break;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " op_done count"}, sel ? (done16 - base_done) : (done32 - base_done), 1);
        nexp = exp_q.size();
        rd0  = sel ? rd16 : rd32;
        for (int i = 0; i < nexp; i++) begin
            e = exp_q.pop_front();
            wr_now = sel ? wr16 : wr32;
            if (rd0 + i < wr_now) o = {1'b0, sel ? obs16[rd0 + i] : obs32[rd0 + i]};
            else                  o = 9'h1FF;
            chk({tag, " byte"}, o, {1'b0, e});
        end
        wr_now = sel ? wr16 : wr32;
        chk({tag, " byte count"}, wr_now - rd0, nexp);
        if (sel) rd16 = wr16; else rd32 = wr32;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " outs32"}, {b32.tx_byte, b32.tx_valid, b32.busy, b32.op_done,
                              b32.frame_err, b32.rx_drop}, 0);
        chk({tag, " outs16"}, {b16.tx_byte, b16.tx_valid, b16.busy, b16.op_done,
                              b16.frame_err, b16.rx_drop}, 0);
    endtask

    initial begin
        logic [7:0] byte2;
        int base_f, wr_before, drop_base, start;

        rst = 1'b1;
        b32.rx_valid = 1'b0; b32.rx_byte = 8'h00; b32.tx_ready = 1'b1;
        b16.rx_valid = 1'b0; b16.rx_byte = 8'h00; b16.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame(0, 8'h01, 64'hFFFF_FFFF, 64'h2, 1);
        wait_resp(0, "add32 carry");
        send_frame(0, 8'h06, 64'd100, 64'h0, 1);
        wait_resp(0, "c2f 100");
        send_frame(0, 8'h06, 64'hFFFF_FFD8, 64'h0, 1);
        wait_resp(0, "c2f -40");
        send_frame(0, 8'h06, 64'hFFFF_FFEF, 64'h0, 1);
        wait_resp(0, "c2f -17");

        send_frame(1, 8'h02, 64'h0003, 64'h0005, 1);
        wait_resp(1, "sub16 borrow");
        send_frame(1, 8'h7F, 64'hABCD, 64'h1234, 1);
        wait_resp(1, "bad op16");

        // partial frame abandoned: opcode plus two A bytes, then silence
        base_f = ferr32;
        wr_before = wr32;
        send_byte(0, 8'h00);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        repeat (80) @(posedge clk);
        #1;
        chk("timeout frame_err", ferr32 - base_f, 1);
        chk("timeout busy", b32.busy, 0);
        chk("timeout no tx", wr32 - wr_before, 0);
        send_frame(0, 8'h00, 64'h1234_5678, 64'h9ABC_DEF0, 1);
        wait_resp(0, "pass after timeout");

        send_frame(0, 8'h05, 64'h0F0F_1234, 64'h00FF_00FF, 1);
        byte2 = exp_q[2];
        start = wr32;
        for (int i = 0; i < 100; i++) begin
            if (wr32 - start >= 2) break;
            @(posedge clk); #1;
        end
        b32.tx_ready = 1'b0;
        drop_base = drop32;
        for (int i = 0; i < 20; i++) begin
            b32.rx_valid = (i % 5 == 0);
            b32.rx_byte  = 8'hAA;
            @(posedge clk); #1;
            b32.rx_valid = 1'b0;
            chk("stall tx_byte", b32.tx_byte, byte2);
        end
        chk("stall tx_valid", b32.tx_valid, 1);
        @(posedge clk); #1;
        chk("rx_drop count", drop32 - drop_base, 4);
        b32.tx_ready = 1'b1;
        wait_resp(0, "xor after stall");

        // reset while receiving B
        send_byte(0, 8'h03);
        for (int i = 0; i < 4; i++) send_byte(0, 8'h5A);
        send_byte(0, 8'hC3);
        send_byte(0, 8'h3C);
        rst = 1'b1;
        #1;
        chk_reset("reset in rx_b");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(0, 8'h04, 64'h1200_0034, 64'h0056_7800, 1);
        wait_resp(0, "or after rst");

        // reset while a response is stalled
        b32.tx_ready = 1'b0;
        send_frame(0, 8'h03, 64'hFFFF_0000, 64'h0F0F_0F0F, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("tx pending before rst", b32.tx_valid, 1);
        rst = 1'b1;
        #1;
        chk_reset("reset in tx");
        @(posedge clk); #1;
        rst = 1'b0;
        b32.tx_ready = 1'b1;
        rd32 = wr32;
        @(posedge clk); #1;
        send_frame(0, 8'h02, 64'd16, 64'd3, 1);
        wait_resp(0, "sub after rst");

        chk("busy at op_done", busy_at_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_frame_alu.md
# uart_frame_alu

Byte-stream operation engine between the UART byte core and a parametrised datapath. It collects a framed request from received bytes: opcode, operand A, operand B. It then executes one of several integer operations, including the Celsius-to-Fahrenheit conversion, and streams back a status byte followed by the result. This replaces the fixed-width, single-function, purely combinational converter path with a sequenced, width-generic, multi-op engine that has frame timeout and overrun handling.

## Interface
- OPER_W, 32, operand/result width in bits; multiple of 8, range 8..64; NB = OPER_W/8.
- TIMEOUT_CYC, 1_000_000, maximum sys_clk cycles between received bytes inside a frame.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe; rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- tx_byte  out  8  byte to transmit.
- tx_valid  out  1  tx_byte is valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_byte on a cycle where tx_valid&tx_ready.
- busy  out  1  high in any state other than IDLE.
- op_done  out  1  one-cycle pulse when the last response byte is accepted.
- frame_err  out  1  one-cycle pulse on an inter-byte timeout abort.
- rx_drop  out  1  one-cycle pulse when an rx_valid byte is discarded (EXEC/TX).

## Operation
- Frame, in received order: opcode byte, then A as NB bytes LSB first, then B as NB bytes LSB first. Total frame is 1+2·NB bytes. B is always sent, even when the op ignores it.
- Opcodes (A, B treated as OPER_W-bit values):
  - 0x00: R = A.
  - 0x01: R = A+B mod 2^OPER_W; flag = carry-out.
  - 0x02: R = A−B mod 2^OPER_W; flag = borrow (A<B unsigned).
  - 0x03: R = A&B.
  - 0x04: R = A|B.
  - 0x05: R = A^B.
  - 0x06: Celsius to Fahrenheit. A is signed; R = trunc_toward_zero(A·9/5) + 32, wrapped to OPER_W. The intermediate is computed at OPER_W+4 bits signed; flag = 0.
  - Any other opcode: R = 0, bad_op = 1.
- Status byte: bit7 = bad_op, bit0 = flag, bits 6:1 = 0.
- Response: status byte, then R as NB bytes LSB first, for 1+NB bytes total.
- States and transitions:
  - IDLE → RX_OP on rx_valid. That byte is the opcode; RX_OP is transient: the opcode is latched and the engine goes directly to RX_A.
  - RX_A collects NB bytes, then goes to RX_B.
  - RX_B collects NB bytes, then goes to EXEC.
  - EXEC lasts one cycle: R, flag and bad_op are registered. Then TX.
  - TX presents 1+NB bytes. After the last byte is accepted it pulses op_done and returns to IDLE.
- Byte counter: width clog2(NB+1). It resets to 0 on each state entry.
- Timeout counter: runs in RX_A/RX_B and clears on each rx_valid. When it reaches TIMEOUT_CYC, the engine pulses frame_err, discards the partial frame and goes to IDLE next cycle. The counter is not active in IDLE, EXEC or TX.
- rx_valid in EXEC or TX: the byte is discarded and rx_drop pulses. No queuing.
- rx_valid on the same cycle the timeout fires: the timeout wins and the byte is dropped silently.
- Reset mid-frame or mid-response aborts immediately. The next byte after release is treated as an opcode.

## Timing
- Reset values: tx_byte=0x00, tx_valid=0, busy=0, op_done=0, frame_err=0, rx_drop=0. The FSM enters IDLE and all counters and operand registers are 0.
- Last B byte accepted at edge N. EXEC is active in cycle N+1. tx_valid rises with the status byte after edge N+2.
- tx handshake:
  - The byte advances on the edge where tx_valid&tx_ready; the next byte is valid in the following cycle.
  - Bytes are back-to-back if tx_ready is held high.
  - tx_byte must not change while tx_valid=1 and tx_ready=0.
- op_done pulses in the cycle after the final handshake edge, with busy=0 in that same cycle.
- Minimum turnaround: 1+2·NB receive strobes, plus 2 cycles, plus 1+NB transmit handshakes.

## Test plan
- OPER_W=32, op 0x01, A=0xFFFFFFFF, B=0x00000002 → response 0x01, 0x01,0x00,0x00,0x00 (R=1, carry set). op_done pulses once.
- OPER_W=32, op 0x06, A=100 → 0x00, then 212 LSB first (0xD4,0x00,0x00,0x00). Then A=−40 (0xD8,0xFF,0xFF,0xFF) → R=0xFFFFFFD8.
- OPER_W=16, op 0x02, A=0x0003, B=0x0005 → 0x01, 0xFE, 0xFF. Op 0x7F with any operands → 0x80, 0x00, 0x00.
- TIMEOUT_CYC=50: send opcode and 2 bytes of A, then idle 50 cycles → frame_err pulses once, busy drops, no tx_valid. A following full op-0x00 frame returns A correctly.
- tx_ready held low 20 cycles on byte 2 → tx_byte stable throughout. rx_valid pulses during TX → rx_drop pulses each time and the response is unchanged.
- Assert rst during RX_B and again during TX → all outputs at reset values immediately. The next frame is processed from its opcode byte.
